// File: rtl/alu_multicycle.sv
// ---------------------------------------------------------------------------
// alu_multicycle
//   Small ALU with single-cycle logic/arithmetic ops and iterative
//   multi-cycle unsigned multiply, divide and remainder.
//
// Ports
//   clk     in   1      clock, rising edge
//   reset   in   1      asynchronous active-high reset
//   start   in   1      request, sampled only while idle
//   gin     in   4      operation code, captured on acceptance
//   a, b    in   WIDTH  operands, captured on acceptance
//   result  out  WIDTH  registered result, held until next completion
//   status  out  4      registered flags {n,z,v,c}
//   busy    out  1      high while a multi-cycle operation runs
//   done    out  1      one-cycle pulse when result/status/err update
//   err     out  1      registered, high when the completed op was illegal
// ---------------------------------------------------------------------------
module alu_multicycle #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       gin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       status,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_NOR  = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_MULU = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1001;
    localparam logic [3:0] OP_REMU = 4'b1010;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // n and z always come from the final result; v and c are op-specific
    function automatic logic [3:0] build_status(input logic [WIDTH-1:0] res,
                                                input logic v,
                                                input logic c);
        build_status = {res[WIDTH-1], (res == {WIDTH{1'b0}}), v, c};
    endfunction

    logic [0:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic [3:0]       r_op;
    logic [WIDTH-1:0] r_hi;    // MUL: partial product high half; DIV: partial remainder
    logic [WIDTH-1:0] r_lo;    // MUL: multiplier / product low half; DIV: dividend / quotient
    logic [WIDTH-1:0] r_opb;   // multiplicand or divisor

    logic [WIDTH:0]   w_add_full;
    logic [WIDTH:0]   w_sub_full;
    logic             w_add_v;
    logic             w_sub_v;
    logic [WIDTH-1:0] w_sc_result;
    logic             w_sc_v;
    logic             w_sc_c;
    logic             w_sc_err;
    logic             w_is_multi;

    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH:0]   w_div_shift;
    logic             w_div_ge;
    logic [WIDTH-1:0] w_div_rem;
    logic [WIDTH-1:0] w_hi_nx;
    logic [WIDTH-1:0] w_lo_nx;
    logic [WIDTH-1:0] w_mc_result;
    logic             w_mc_v;

    assign w_add_full = {1'b0, a} + {1'b0, b};
    // Subtract as a + ~b + 1 so that carry out means "no borrow"
    assign w_sub_full = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    assign w_add_v    = (a[WIDTH-1] == b[WIDTH-1]) && (w_add_full[WIDTH-1] != a[WIDTH-1]);
    assign w_sub_v    = (a[WIDTH-1] != b[WIDTH-1]) && (w_sub_full[WIDTH-1] != a[WIDTH-1]);
    assign w_is_multi = (gin == OP_MULU) || (gin == OP_DIVU) || (gin == OP_REMU);

    // Single-cycle datapath, evaluated straight from the input operands
    always_comb begin
        w_sc_result = {WIDTH{1'b0}};
        w_sc_v      = 1'b0;
        w_sc_c      = 1'b0;
        w_sc_err    = 1'b0;
        case (gin)
            OP_AND: w_sc_result = a & b;
            OP_OR:  w_sc_result = a | b;
            OP_XOR: w_sc_result = a ^ b;
            OP_NOR: w_sc_result = ~(a | b);
            OP_ADD: begin
                w_sc_result = w_add_full[WIDTH-1:0];
                w_sc_v      = w_add_v;
                w_sc_c      = w_add_full[WIDTH];
            end
            OP_SUB: begin
                w_sc_result = w_sub_full[WIDTH-1:0];
                w_sc_v      = w_sub_v;
                w_sc_c      = w_sub_full[WIDTH];
            end
            OP_SLT: begin
                // Sign of the difference corrected by overflow gives signed a<b
                w_sc_result = {{(WIDTH-1){1'b0}}, w_sub_full[WIDTH-1] ^ w_sub_v};
                w_sc_v      = w_sub_v;
                w_sc_c      = w_sub_full[WIDTH];
            end
            default: begin
                // Illegal codes (multi-cycle codes never take this path)
                w_sc_result = {WIDTH{1'b0}};
                w_sc_err    = 1'b1;
            end
        endcase
    end

    // One shift-add step: add multiplicand when the multiplier LSB is set, shift right
    assign w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : {(WIDTH+1){1'b0}});
    // One restoring-division step: bring in the next dividend bit and try to subtract
    assign w_div_shift = {r_hi, r_lo[WIDTH-1]};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_opb});
    // The true difference always fits WIDTH bits when it is kept
    assign w_div_rem   = w_div_shift[WIDTH-1:0] - r_opb;

    // Next iteration values for the multi-cycle datapath
    always_comb begin
        w_hi_nx = r_hi;
        w_lo_nx = r_lo;
        if (r_op == OP_MULU) begin
            w_hi_nx = w_mul_sum[WIDTH:1];
            w_lo_nx = {w_mul_sum[0], r_lo[WIDTH-1:1]};
        end else if (w_div_ge) begin
            w_hi_nx = w_div_rem;
            w_lo_nx = {r_lo[WIDTH-2:0], 1'b1};
        end else begin
            w_hi_nx = w_div_shift[WIDTH-1:0];
            w_lo_nx = {r_lo[WIDTH-2:0], 1'b0};
        end
    end

    // Final multi-cycle result selection; a zero divisor naturally yields
    // an all-ones quotient and a remainder equal to the dividend
    always_comb begin
        w_mc_result = w_lo_nx;
        w_mc_v      = 1'b0;
        case (r_op)
            OP_MULU: begin
                w_mc_result = w_lo_nx;
                w_mc_v      = (w_hi_nx != {WIDTH{1'b0}});
            end
            OP_DIVU: begin
                w_mc_result = w_lo_nx;
                w_mc_v      = (r_opb == {WIDTH{1'b0}});
            end
            OP_REMU: begin
                w_mc_result = w_hi_nx;
                w_mc_v      = (r_opb == {WIDTH{1'b0}});
            end
            default: begin
                w_mc_result = w_lo_nx;
                w_mc_v      = 1'b0;
            end
        endcase
    end

    assign busy = (r_state == ST_RUN);

    // Control FSM, operand capture, iteration and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= {CW{1'b0}};
            r_op    <= 4'b0000;
            r_hi    <= {WIDTH{1'b0}};
            r_lo    <= {WIDTH{1'b0}};
            r_opb   <= {WIDTH{1'b0}};
            result  <= {WIDTH{1'b0}};
            status  <= 4'b0000;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start && w_is_multi) begin
                        r_state <= ST_RUN;
                        r_cnt   <= CW'(WIDTH);
                        r_op    <= gin;
                        r_hi    <= {WIDTH{1'b0}};
                        r_lo    <= a;
                        r_opb   <= b;
                        done    <= 1'b0;
                    end else if (start) begin
                        result  <= w_sc_result;
                        status  <= build_status(w_sc_result, w_sc_v, w_sc_c);
                        err     <= w_sc_err;
                        done    <= 1'b1;
                    end else begin
                        done    <= 1'b0;
                    end
                end
                ST_RUN: begin
                    r_hi  <= w_hi_nx;
                    r_lo  <= w_lo_nx;
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_state <= ST_IDLE;
                        result  <= w_mc_result;
                        status  <= build_status(w_mc_result, w_mc_v, 1'b0);
                        err     <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        done    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
module tb_alu_multicycle;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [3:0]    gin;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [W-1:0]  result;
    logic [3:0]    status;
    logic          busy;
    logic          done;
    logic          err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_multicycle #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .gin(gin), .a(a), .b(b),
        .result(result), .status(status), .busy(busy), .done(done), .err(err)
    );

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic [3:0]   st;
        logic         er;
    } vec_t;

    vec_t tbl[16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic bit is_multi(input logic [3:0] op);
        return (op == 4'd8) || (op == 4'd9) || (op == 4'd10);
    endfunction

    // Reference: plain arithmetic on wide/signed integers
    function automatic void ref_model(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                                      output logic [W-1:0] res, output logic [3:0] st, output logic e);
        logic [63:0] wide;
        longint sx;
        longint sy;
        longint s;
        logic v;
        logic c;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        v = 1'b0;
        c = 1'b0;
        e = 1'b0;
        res = '0;
        case (op)
            4'd0: res = x & y;
            4'd1: res = x | y;
            4'd3: res = x ^ y;
            4'd4: res = ~(x | y);
            4'd2: begin
                wide = {32'd0, x} + {32'd0, y};
                res = wide[31:0];
                c = wide[32];
                s = sx + sy;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd6: begin
                res = x - y;
                c = (x >= y);
                s = sx - sy;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd7: begin
                c = (x >= y);
                s = sx - sy;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
                res = (sx < sy) ? 32'd1 : 32'd0;
            end
            4'd8: begin
                wide = {32'd0, x} * {32'd0, y};
                res = wide[31:0];
                v = (wide[63:32] != 32'd0);
            end
            4'd9: begin
                if (y == 32'd0) begin res = 32'hFFFF_FFFF; v = 1'b1; end
                else res = x / y;
            end
            4'd10: begin
                if (y == 32'd0) begin res = x; v = 1'b1; end
                else res = x % y;
            end
            default: begin
                res = 32'd0;
                e = 1'b1;
            end
        endcase
        st = {res[31], (res == 32'd0), v, c};
    endfunction

    // Issue one op, optionally keep start high and scramble inputs while busy.
    // n = index of the negedge (1 = first after acceptance) where done appeared, 0 on timeout.
    task automatic run_op(input logic [3:0] op, input logic [W-1:0] oa, input logic [W-1:0] ob,
                          input bit hold, output logic [W-1:0] r, output logic [3:0] s,
                          output logic e, output int n, output int busy_n);
        @(negedge clk);
        start = 1'b1;
        gin = op;
        a = oa;
        b = ob;
        n = 0;
        busy_n = 0;
        for (int i = 1; i <= W + 8; i++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (done) begin
                n = i;
                break;
            end
            start = hold;
            gin = 4'($urandom);
            a = W'($urandom);
            b = W'($urandom);
        end
        start = 1'b0;
        r = result;
        s = status;
        e = err;
    endtask

    task automatic run_and_check(input string tag, input logic [3:0] op, input logic [W-1:0] oa,
                                 input logic [W-1:0] ob, input bit hold,
                                 input logic [W-1:0] er, input logic [3:0] es, input logic ee);
        logic [W-1:0] r;
        logic [3:0] s;
        logic e;
        int n;
        int bn;
        run_op(op, oa, ob, hold, r, s, e, n, bn);
        check({tag, " latency"}, 64'(n), is_multi(op) ? 64'(W + 1) : 64'd1);
        check({tag, " result"}, 64'(r), 64'(er));
        check({tag, " status"}, 64'(s), 64'(es));
        check({tag, " err"}, 64'(e), 64'(ee));
        if (is_multi(op)) check({tag, " busy_cycles"}, 64'(bn), 64'(W));
    endtask

    initial begin
        logic [W-1:0] mr;
        logic [3:0] ms;
        logic me;
        logic [W-1:0] bb_res[8];
        logic [3:0] bb_st[8];
        logic bb_err[8];
        logic [3:0] sc_ops[8];
        logic [3:0] all_ops[12];
        logic [W-1:0] corners[4];
        int done_seen;

        tbl[0]  = '{4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b1010, 1'b0};
        tbl[1]  = '{4'b0110, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 4'b0101, 1'b0};
        tbl[2]  = '{4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 4'b0001, 1'b0};
        tbl[3]  = '{4'b0111, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 4'b0011, 1'b0};
        tbl[4]  = '{4'b1000, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 4'b0110, 1'b0};
        tbl[5]  = '{4'b1001, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 4'b0000, 1'b0};
        tbl[6]  = '{4'b1010, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 4'b0000, 1'b0};
        tbl[7]  = '{4'b1001, 32'h1234_5678, 32'h0000_0000, 32'hFFFF_FFFF, 4'b1010, 1'b0};
        tbl[8]  = '{4'b1010, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 4'b0010, 1'b0};
        tbl[9]  = '{4'b1111, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 4'b0100, 1'b1};
        tbl[10] = '{4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 4'b1000, 1'b0};
        tbl[11] = '{4'b0001, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 4'b0100, 1'b0};
        tbl[12] = '{4'b0011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 4'b0100, 1'b0};
        tbl[13] = '{4'b0100, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 4'b1000, 1'b0};
        tbl[14] = '{4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b0101, 1'b0};
        tbl[15] = '{4'b0110, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 4'b1000, 1'b0};

        sc_ops  = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd7, 4'd15};
        all_ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd5, 4'd15};
        corners = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

        reset = 1'b1;
        start = 1'b0;
        gin = 4'd0;
        a = '0;
        b = '0;
        repeat (2) @(negedge clk);
        check("reset result", 64'(result), 64'd0);
        check("reset status", 64'(status), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset err", 64'(err), 64'd0);
        reset = 1'b0;

        // Directed vectors; the MULU one keeps start asserted while busy
        for (int i = 0; i < 16; i++) begin
            run_and_check($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, (i == 4),
                          tbl[i].res, tbl[i].st, tbl[i].er);
        end

        // Back-to-back single-cycle acceptance, one op per clock
        @(negedge clk);
        for (int i = 0; i <= 8; i++) begin
            if (i > 0) begin
                check($sformatf("b2b%0d done", i - 1), 64'(done), 64'd1);
                check($sformatf("b2b%0d result", i - 1), 64'(result), 64'(bb_res[i-1]));
                check($sformatf("b2b%0d status", i - 1), 64'(status), 64'(bb_st[i-1]));
                check($sformatf("b2b%0d err", i - 1), 64'(err), 64'(bb_err[i-1]));
            end
            if (i < 8) begin
                start = 1'b1;
                gin = sc_ops[i];
                a = W'($urandom);
                b = W'($urandom);
                ref_model(gin, a, b, bb_res[i], bb_st[i], bb_err[i]);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end

        // Reset in the middle of a DIVU aborts it without a done pulse
        run_and_check("pre_abort", 4'd4, 32'd0, 32'd0, 1'b0, 32'hFFFF_FFFF, 4'b1000, 1'b0);
        @(negedge clk);
        start = 1'b1;
        gin = 4'd9;
        a = 32'h0000_0064;
        b = 32'h0000_0007;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("abort busy_before", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        check("abort result", 64'(result), 64'd0);
        check("abort status", 64'(status), 64'd0);
        check("abort busy", 64'(busy), 64'd0);
        check("abort done", 64'(done), 64'd0);
        check("abort err", 64'(err), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        done_seen = 0;
        for (int i = 0; i < W + 4; i++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check("abort no_done", 64'(done_seen), 64'd0);
        run_and_check("post_abort_add", 4'd2, 32'd2, 32'd3, 1'b0, 32'd5, 4'b0000, 1'b0);

        // Randomized ops against the reference model
        for (int i = 0; i < 150; i++) begin
            logic [3:0] op;
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            int mode;
            op = all_ops[$urandom_range(11, 0)];
            mode = $urandom_range(3, 0);
            ra = W'($urandom);
            rb = W'($urandom);
            if (mode == 1) rb = '0;
            if (mode == 2) begin
                ra = corners[$urandom_range(3, 0)];
                rb = corners[$urandom_range(3, 0)];
            end
            if (mode == 3) begin
                ra = W'($urandom_range(300, 0));
                rb = W'($urandom_range(20, 0));
            end
            ref_model(op, ra, rb, mr, ms, me);
            run_and_check($sformatf("rnd%0d op%0h", i, op), op, ra, rb, bit'($urandom_range(1, 0)), mr, ms, me);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits (legal range 8..64).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request; sampled only while busy=0.
REQ-005 gin  input  4  operation code, captured on acceptance.
REQ-006 a, b  input  WIDTH each  operands, captured on acceptance.
REQ-007 result  output  WIDTH  registered result; holds until the next completion.
REQ-008 status  output  4  registered flags {n,z,v,c}, bit3..bit0.
REQ-009 busy  output  1  high while a multi-cycle operation runs.
REQ-010 done  output  1  one-cycle pulse: result/status/err just updated.
REQ-011 err  output  1  registered; high when the completed op code was illegal.

Function
REQ-012 Op codes SHALL be: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 0011 XOR, 0100 NOR (single-cycle); 1000 MULU low half, 1001 DIVU quotient, 1010 REMU remainder (multi-cycle); all others illegal.
REQ-013 States SHALL be IDLE and RUN; busy=1 exactly in RUN.
REQ-014 start=1 in IDLE SHALL be accepted at that edge; start in RUN SHALL be ignored, not queued.
REQ-015 Single-cycle or illegal op accepted at edge k: result/status/err updated and done=1 during cycle after edge k; state stays IDLE; back-to-back acceptance every cycle SHALL be supported.
REQ-016 Multi-cycle op accepted at edge k: state to RUN, iteration counter loaded with WIDTH, one shift-add (MUL) or restoring shift-subtract (DIV/REM) step per cycle; at edge k+WIDTH result/status written, state to IDLE, done=1 for that one cycle.
REQ-017 Operand changes on a, b, gin during RUN SHALL not affect the running operation.
REQ-018 ADD: sum modulo 2^WIDTH; c=carry out; v=1 iff operand signs equal and result sign differs.
REQ-019 SUB: a+~b+1; c=carry out (1 = no borrow); v=1 iff operand signs differ and result sign differs from a.
REQ-020 SLT: result=1 iff a<b signed, computed as (a-b)[WIDTH-1] XOR v; else 0; v, c from the subtraction; n from result.
REQ-021 Logic ops: v=0, c=0.
REQ-022 MULU: result=low WIDTH bits of unsigned product; v=1 iff high WIDTH bits nonzero; c=0.
REQ-023 DIVU/REMU with b=0: quotient all ones, remainder=a, v=1, c=0; latency unchanged (WIDTH cycles).
REQ-024 DIVU/REMU with b!=0: unsigned truncating; v=0, c=0.
REQ-025 For every op: n=result[WIDTH-1], z=1 iff result==0 (computed on the final result).
REQ-026 Illegal op: result=0, status=0100, err=1; legal completion SHALL clear err.

Reset
REQ-027 reset=1 SHALL immediately force state IDLE, busy=0, done=0, err=0, result=0, status=0000, counter=0.
REQ-028 reset during RUN SHALL abort the operation with no done pulse; first start after reset release SHALL be accepted normally.

Verification
REQ-029 WIDTH=32, ADD a=7FFFFFFF b=00000001 -> next cycle done=1, result=80000000, status=1010.
REQ-030 SUB a=00000005 b=00000005 -> result=0, status=0101; SLT a=FFFFFFFF b=00000001 -> result=1; SLT a=80000000 b=7FFFFFFF -> result=1 (overflow case).
REQ-031 MULU a=00010000 b=00010000 -> busy 32 cycles, done at edge k+32, result=0, status=0110; start pulses during busy ignored.
REQ-032 DIVU a=00000064 b=00000007 -> result=0000000E; REMU same -> 00000002; DIVU b=0 a=12345678 -> FFFFFFFF, v=1; REMU b=0 -> 12345678.
REQ-033 Start DIVU, assert reset at cycle 10 of RUN -> outputs zero immediately, no done; subsequent ADD 2+3 -> result=5 one cycle later.
REQ-034 gin=1111 -> done=1, result=0, status=0100, err=1; following legal AND -> err=0.
